serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8, payload bits per frame (legal 2..32).
REQ-002 Parameter PRE_LEN, default 2, number of preamble 1-bits per frame (legal 1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 areset_n  input  1  asynchronous, active-low reset.
REQ-005 data  input  WIDTH  payload word, sampled on accept.
REQ-006 valid  input  1  payload word offered.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  registered serial bit stream, one bit per clk.
REQ-009 busy  output  1  registered; high while a frame is on sout.
REQ-010 done  output  1  registered one-cycle pulse coincident with the stop bit.

Function
REQ-011 Accept SHALL occur on a rising edge where valid && ready; data is captured into an internal shift register.
REQ-012 The FSM SHALL have states IDLE, PRE, DATA, PAR, STOP.
REQ-013 ready SHALL be combinational: 1 in IDLE and in STOP, else 0.
REQ-014 IDLE: sout=0, busy=0. Accept -> PRE.
REQ-015 PRE: sout=1 for exactly PRE_LEN cycles -> DATA.
REQ-016 DATA: sout = payload MSB first, WIDTH cycles -> PAR if PARITY_EN is defined, else STOP.
REQ-017 PAR: sout = even parity (XOR of all payload bits) for one cycle -> STOP.
REQ-018 STOP: sout=0 and done=1 for one cycle. Accept in this cycle -> PRE with no idle gap; otherwise -> IDLE.
REQ-019 Latency: first preamble bit SHALL appear on sout in the cycle after the accepting edge.
REQ-020 Frame length SHALL be PRE_LEN+WIDTH+2 cycles with parity and PRE_LEN+WIDTH+1 without.
REQ-021 busy SHALL be 1 in PRE, DATA, PAR and STOP.
REQ-022 valid asserted in PRE/DATA/PAR SHALL be ignored; data changes there SHALL NOT affect the frame in flight.
REQ-023 Bit and preamble counters SHALL be sized to hold max(WIDTH, PRE_LEN)-1 and SHALL clear on every state entry.

Reset
REQ-024 areset_n=0 SHALL force IDLE immediately, independent of clk: sout=0, busy=0, done=0, ready=1, shift register and counters 0.
REQ-025 Reset mid-frame SHALL abort the frame with no partial resumption; the next accept after release starts a full frame.
REQ-026 The first accept SHALL be possible on the first rising edge after areset_n deasserts.

Configuration
REQ-027 Macro SERIAL_PATTERN_TX_PARITY_EN: defined -> PAR state and even-parity bit present. Undefined -> PAR state, parity logic and parity register are absent, and DATA goes directly to STOP.

Structure
REQ-028 Package serial_pattern_tx_pkg SHALL hold the state enumeration, PRE_BIT=1'b1 and STOP_BIT=1'b0.
REQ-029 Sub-module serial_pattern_tx_shreg SHALL implement a WIDTH-bit load/shift-left register with MSB output; the FSM and counters stay in the top module.

Verification
REQ-030 With parity, data=8'hA5 accepted once -> sout = 1,1,1,0,1,0,0,1,0,1,0,0 over 12 cycles; done high only in cycle 12; then IDLE.
REQ-031 Back-to-back: 8'h00 offered, then 8'hFF offered during STOP -> no idle gap. Second frame = 1,1, eight 1s, parity 0, stop 0. ready seen 1 in each STOP cycle.
REQ-032 valid=1 with data=8'h3C held through frame 8'h81 -> 8'h81 transmits unchanged; 8'h3C is accepted in STOP and follows.
REQ-033 areset_n pulsed low during DATA bit 4 -> sout=0, busy=0 with no clk edge needed. After release, accept 8'h5A -> full 12-cycle frame.
REQ-034 Macro undefined, data=8'hA5 -> 11-cycle frame 1,1,1,0,1,0,0,1,0,1,0.
REQ-035 Loopback: output drives the team's two-consecutive-1s detector -> detector output high on the second preamble bit of every frame.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The PAR state only exists when SERIAL_PATTERN_TX_PARITY_EN is defined.
package serial_pattern_tx_pkg;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_STOP = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_STOP = 3'd4
    } state_e;
`endif

    localparam logic PRE_BIT  = 1'b1;
    localparam logic STOP_BIT = 1'b0;

    // Width needed for a counter that must hold max(width, pre_len)-1.
    function automatic int cnt_width(input int width, input int pre_len);
        int m;
        m = (width > pre_len) ? width : pre_len;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/serial_pattern_tx_shreg.sv
// WIDTH-bit load / shift-left register exposing its MSB.
module serial_pattern_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Framed serial transmitter: preamble 1s, payload MSB first, optional even
// parity (SERIAL_PATTERN_TX_PARITY_EN), stop 0. Outputs are registered.
//
// state | meaning
// IDLE  | line low, waiting for a word
// PRE   | PRE_LEN preamble 1-bits
// DATA  | WIDTH payload bits, MSB first
// PAR   | even parity of payload (parity build only)
// STOP  | stop bit 0, done pulse, may accept the next word
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRE_LEN = 2
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH, PRE_LEN);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          sr_load;
    logic          sr_shift;
    logic          sr_msb;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_STOP);
    assign accept = valid && ready;

    serial_pattern_tx_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (sr_load),
        .shift    (sr_shift),
        .din      (data),
        .msb      (sr_msb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_STOP;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            ST_PAR: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
`endif
            ST_STOP: begin
                state_d = accept ? ST_PRE : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so the first preamble bit
    // appears right after the accepting edge. The shift that consumes the MSB
    // happens on the same edge that registers it onto sout.
    always_comb begin
        sr_load  = accept;
        sr_shift = (state_d == ST_DATA);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_STOP);
        sout_d   = 1'b0;
        case (state_d)
            ST_PRE:  sout_d = PRE_BIT;
            ST_DATA: sout_d = sr_msb;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            ST_PAR:  sout_d = parity_q;
`endif
            ST_STOP: sout_d = STOP_BIT;
            default: sout_d = 1'b0;
        endcase
    end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign parity_d = accept ? ^data : parity_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; expected frames follow the build
// selected by SERIAL_PATTERN_TX_PARITY_EN.
module tb_serial_pattern_tx;

    localparam int WIDTH   = 8;
    localparam int PRE_LEN = 2;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int FL = PRE_LEN + WIDTH + 2;
    localparam logic [31:0] A5_LIT = 32'b1110_1001_0100;
`else
    localparam int FL = PRE_LEN + WIDTH + 1;
    localparam logic [31:0] A5_LIT = 32'b111_0100_1010;
`endif

    logic       clk      = 1'b0;
    logic       areset_n = 1'b0;
    logic       valid    = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       ready, sout, busy, done;
    logic       prev_sout = 1'b0;
    logic [31:0] got;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(
        .WIDTH   (WIDTH),
        .PRE_LEN (PRE_LEN)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // prev_sout feeds a two-consecutive-1s detector on the serial line.
    task automatic tick();
        prev_sout = sout;
        @(posedge clk);
        #1;
    endtask

    // Expected frame with cycle 0 in the most significant used bit.
    function automatic logic [31:0] frame_bits(input logic [7:0] d);
        logic [31:0] f;
        f = '0;
        for (int p = 0; p < PRE_LEN; p++) f = {f[30:0], 1'b1};
        for (int b = 7; b >= 0; b--) f = {f[30:0], d[b]};
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        f = {f[30:0], ^d};
`endif
        f = {f[30:0], 1'b0};
        return f;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_sout"},  sout,  1'b0);
        check({tag, "_busy"},  busy,  1'b0);
        check({tag, "_done"},  done,  1'b0);
        check({tag, "_ready"}, ready, 1'b1);
    endtask

    // Called in the first cycle of a frame; returns after the stop cycle.
    task automatic run_frame(input string tag, input logic [7:0] d,
                             input logic hold, input logic [7:0] hold_data,
                             input logic nxt_valid, input logic [7:0] nxt_data,
                             output logic [31:0] bits);
        bits = '0;
        for (int i = 0; i < FL; i++) begin
            if (hold) begin
                valid = 1'b1;
                data  = hold_data;
            end
            bits = {bits[30:0], sout};
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done"}, done, (i == FL - 1));
            if (i == 1) check({tag, "_det"}, sout & prev_sout, 1'b1);
            if (i == FL - 1) begin
                check({tag, "_ready_stop"}, ready, 1'b1);
                valid = nxt_valid;
                data  = nxt_data;
            end else begin
                check({tag, "_ready_busy"}, ready, 1'b0);
            end
            tick();
        end
        check({tag, "_bits"}, bits, frame_bits(d));
    endtask

    initial begin
        #2;
        check_idle("reset");
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // Single frame, accepted on the first edge after reset release.
        valid = 1'b1;
        data  = 8'hA5;
        tick();
        valid = 1'b0;
        data  = 8'hFF;
        run_frame("a5", 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, got);
        check("a5_literal", got, A5_LIT);
        check_idle("a5_after");
        tick();
        check_idle("a5_idle");

        // Back-to-back frames with the second word offered during STOP.
        valid = 1'b1;
        data  = 8'h00;
        tick();
        valid = 1'b0;
        run_frame("b2b_00", 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, got);
        valid = 1'b0;
        data  = 8'h00;
        run_frame("b2b_ff", 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, got);
        check_idle("b2b_after");

        // valid/data held mid-frame must not disturb the frame in flight.
        valid = 1'b1;
        data  = 8'h81;
        tick();
        run_frame("hold_81", 8'h81, 1'b1, 8'h3C, 1'b1, 8'h3C, got);
        valid = 1'b0;
        data  = 8'h00;
        run_frame("next_3c", 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, got);
        check_idle("hold_after");

        // Asynchronous reset during DATA bit 4.
        valid = 1'b1;
        data  = 8'hC3;
        tick();
        valid = 1'b0;
        for (int i = 0; i < PRE_LEN + 4; i++) tick();
        check("rst_busy_before", busy, 1'b1);
        #2;
        areset_n = 1'b0;
        #1;
        check_idle("rst_async");
        @(posedge clk);
        #1;
        check_idle("rst_held");
        areset_n = 1'b1;
        valid = 1'b1;
        data  = 8'h5A;
        tick();
        valid = 1'b0;
        run_frame("rst_5a", 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, got);
        check_idle("rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
